// File: rtl/operand_sel_pipe_pkg.sv
// Shared constants for the operand select pipeline: error counter sizing
// and the supported range of selectable sources.
package operand_sel_pipe_pkg;

  localparam int unsigned ERR_CNT_W = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'd255;

  localparam int unsigned NSRC_MIN = 2;
  localparam int unsigned NSRC_MAX = 16;

endpackage

// File: rtl/operand_sel_comb.sv
// Combinational NSRC:1 operand select; out-of-range indices return zero
// and raise oor_o so the caller can log the error.
module operand_sel_comb #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 3,
  parameter int SELW  = $clog2(NSRC)
) (
  input  logic [NSRC*WIDTH-1:0] src_i,
  input  logic [SELW-1:0]       sel_i,
  output logic [WIDTH-1:0]      data_o,
  output logic                  oor_o
);

  // Compare against each legal index so no index ever reaches past src_i.
  always_comb begin
    data_o = '0;
    oor_o  = 1'b1;
    for (int k = 0; k < NSRC; k++) begin
      if (sel_i == SELW'(k)) begin
        data_o = src_i[k*WIDTH +: WIDTH];
        oor_o  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/operand_sel_pipe.sv
// Operand select followed by a two-entry skid buffer; in_ready_o comes
// straight from a flop so there is no ready path from the consumer.
module operand_sel_pipe
  import operand_sel_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NSRC  = 3,
  parameter int SELW  = $clog2(NSRC)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic [NSRC*WIDTH-1:0] src_i,
  input  logic [SELW-1:0]       sel_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [WIDTH-1:0]      out_data_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  sel_err_o,
  output logic [ERR_CNT_W-1:0]  err_cnt_o
);

  if (NSRC < NSRC_MIN || NSRC > NSRC_MAX) begin : g_nsrc_range
    $error("operand_sel_pipe: NSRC must lie within 2..16");
  end

  logic [WIDTH-1:0]     sel_data;
  logic                 sel_oor;
  logic                 main_valid;
  logic [WIDTH-1:0]     main_data;
  logic                 skid_valid;
  logic [WIDTH-1:0]     skid_data;
  logic                 sel_err;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic                 accept;
  logic                 drain;

  operand_sel_comb #(
    .WIDTH (WIDTH),
    .NSRC  (NSRC),
    .SELW  (SELW)
  ) u_sel (
    .src_i  (src_i),
    .sel_i  (sel_i),
    .data_o (sel_data),
    .oor_o  (sel_oor)
  );

  assign accept = in_valid_i && !skid_valid && !flush_i;
  assign drain  = main_valid && out_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      sel_err    <= 1'b0;
      err_cnt    <= '0;
    end else if (flush_i) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      if (accept && sel_oor) begin
        sel_err <= 1'b1;
        if (err_cnt != ERR_CNT_MAX) begin
          err_cnt <= err_cnt + 1'b1;
        end
      end
      // Main is free this cycle: refill from skid first to keep FIFO order.
      if (!main_valid || drain) begin
        if (skid_valid) begin
          main_data  <= skid_data;
          main_valid <= 1'b1;
          skid_valid <= 1'b0;
        end else if (accept) begin
          main_data  <= sel_data;
          main_valid <= 1'b1;
        end else begin
          main_valid <= 1'b0;
        end
      end else if (accept) begin
        skid_data  <= sel_data;
        skid_valid <= 1'b1;
      end
    end
  end

  assign in_ready_o  = !skid_valid;
  assign out_data_o  = main_data;
  assign out_valid_o = main_valid;
  assign sel_err_o   = sel_err;
  assign err_cnt_o   = err_cnt;

endmodule

// File: tb/tb_operand_sel_pipe.sv
// Directed bench for operand_sel_pipe (WIDTH=32, NSRC=3).
module tb_operand_sel_pipe;

  logic        clk;
  logic        rst;
  logic        flush_i;
  logic [95:0] src_i;
  logic [1:0]  sel_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] out_data_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic        sel_err_o;
  logic [7:0]  err_cnt_o;

  int n_cmp = 0;
  int n_err = 0;

  operand_sel_pipe #(
    .WIDTH (32),
    .NSRC  (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .src_i       (src_i),
    .sel_i       (sel_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .out_data_o  (out_data_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .sel_err_o   (sel_err_o),
    .err_cnt_o   (err_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, {31'd0, out_valid_o}, 32'd0);
    chk({tag, "_data"},  out_data_o,           32'd0);
    chk({tag, "_ready"}, {31'd0, in_ready_o},  32'd1);
    chk({tag, "_err"},   {31'd0, sel_err_o},   32'd0);
    chk({tag, "_cnt"},   {24'd0, err_cnt_o},   32'd0);
  endtask

  task automatic load_ab();
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    src_i = {32'h0, 32'h0, 32'hAAAA};
    sel_i = 2'd0;
    step();
    src_i = {32'h0, 32'hBBBB, 32'h0};
    sel_i = 2'd1;
    step();
    in_valid_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    src_i = {32'h3, 32'h2, 32'h1}; sel_i = 2'd0;
    step();
    step();
    chk_reset("reset");
    rst = 1'b0;

    // Basic select, one-cycle latency
    out_ready_i = 1'b1; in_valid_i = 1'b1; sel_i = 2'd2;
    step();
    in_valid_i = 1'b0;
    chk("sel2_data",  out_data_o, 32'h3);
    chk("sel2_valid", {31'd0, out_valid_o}, 32'd1);
    step();
    chk("sel2_drained", {31'd0, out_valid_o}, 32'd0);
    in_valid_i = 1'b1; sel_i = 2'd0;
    step();
    in_valid_i = 1'b0;
    chk("sel0_data", out_data_o, 32'h1);
    step();

    // Out-of-range select
    in_valid_i = 1'b1; sel_i = 2'd3;
    step();
    in_valid_i = 1'b0;
    chk("oor_data",  out_data_o, 32'h0);
    chk("oor_valid", {31'd0, out_valid_o}, 32'd1);
    chk("oor_err",   {31'd0, sel_err_o}, 32'd1);
    chk("oor_cnt",   {24'd0, err_cnt_o}, 32'd1);
    step();

    // Backpressure fills skid, then drains in order
    load_ab();
    chk("bp_ready", {31'd0, in_ready_o}, 32'd0);
    chk("bp_dataA", out_data_o, 32'hAAAA);
    step();
    chk("bp_holdA", out_data_o, 32'hAAAA);
    chk("bp_holdv", {31'd0, out_valid_o}, 32'd1);
    out_ready_i = 1'b1;
    step();
    chk("bp_dataB",  out_data_o, 32'hBBBB);
    chk("bp_validB", {31'd0, out_valid_o}, 32'd1);
    chk("bp_ready2", {31'd0, in_ready_o}, 32'd1);
    step();
    chk("bp_empty", {31'd0, out_valid_o}, 32'd0);

    // Flush with both entries full and a new input offered
    load_ab();
    flush_i = 1'b1; in_valid_i = 1'b1; sel_i = 2'd2;
    src_i = {32'hCCCC, 32'h0, 32'h0};
    step();
    flush_i = 1'b0; in_valid_i = 1'b0;
    chk("fl_valid", {31'd0, out_valid_o}, 32'd0);
    chk("fl_ready", {31'd0, in_ready_o}, 32'd1);
    out_ready_i = 1'b1;
    step();
    chk("fl_noC",   {31'd0, out_valid_o}, 32'd0);
    chk("fl_cnt",   {24'd0, err_cnt_o}, 32'd1);

    // Streaming: one output per cycle, never stalls
    out_ready_i = 1'b1; in_valid_i = 1'b1;
    for (int i = 0; i < 100; i++) begin
      src_i = {32'h300 + i, 32'h200 + i, 32'h100 + i};
      sel_i = 2'(i % 3);
      chk("st_ready", {31'd0, in_ready_o}, 32'd1);
      step();
      chk("st_data",  out_data_o, 32'((i % 3 + 1) * 256 + i));
      chk("st_valid", {31'd0, out_valid_o}, 32'd1);
    end
    in_valid_i = 1'b0;
    step();

    // Error counter saturation (count already 1)
    in_valid_i = 1'b1; sel_i = 2'd3;
    for (int j = 0; j < 253; j++) step();
    chk("cnt_254", {24'd0, err_cnt_o}, 32'd254);
    step();
    chk("cnt_255", {24'd0, err_cnt_o}, 32'd255);
    for (int j = 0; j < 46; j++) step();
    chk("cnt_sat", {24'd0, err_cnt_o}, 32'd255);
    in_valid_i = 1'b0;
    step();

    // Reset with both entries full and sticky error set
    load_ab();
    chk("pre_rst_ready", {31'd0, in_ready_o}, 32'd0);
    rst = 1'b1; out_ready_i = 1'b1;
    step();
    chk_reset("midrst");
    rst = 1'b0;
    step();
    chk("post_rst_valid", {31'd0, out_valid_o}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/operand_sel_pipe.md
OPERAND_SEL_PIPE -- requirements
Module: operand_sel_pipe

Interface
REQ-001 Parameter WIDTH, default 32, data width of every source and of the output.
REQ-002 Parameter NSRC, default 3, number of selectable sources; legal range 2..16.
REQ-003 Parameter SELW, default $clog2(NSRC), select width; derived, never overridden.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 flush_i  input  1  discards all buffered entries.
REQ-007 src_i  input  NSRC*WIDTH  flattened sources; source k occupies bits [k*WIDTH +: WIDTH].
REQ-008 sel_i  input  SELW  source index.
REQ-009 in_valid_i  input  1  src_i/sel_i valid.
REQ-010 in_ready_o  output  1  block can accept this cycle.
REQ-011 out_data_o  output  WIDTH  selected, registered operand.
REQ-012 out_valid_o  output  1  out_data_o valid.
REQ-013 out_ready_i  input  1  consumer accepts this cycle.
REQ-014 sel_err_o  output  1  sticky flag: an out-of-range select was accepted.
REQ-015 err_cnt_o  output  8  saturating count of accepted out-of-range selects.

Function
REQ-016 Selection: sel_i < NSRC yields source sel_i; sel_i >= NSRC yields all-zero data.
REQ-017 Selection is resolved at acceptance; stored entries hold selected data, not sel_i.
REQ-018 Input transfer occurs when in_valid_i && in_ready_o && !flush_i.
REQ-019 Output transfer occurs when out_valid_o && out_ready_i.
REQ-020 Storage: two-entry skid buffer; main register drives out_data_o, skid register holds the overflow entry.
REQ-021 Latency: an entry accepted into an empty block appears on out_data_o with out_valid_o=1 in the next cycle.
REQ-022 in_ready_o = !skid_valid; registered, no combinational path from out_ready_i.
REQ-023 Main empty or draining, skid empty: accepted entry loads main.
REQ-024 Main full and not draining: accepted entry loads skid; in_ready_o deasserts next cycle.
REQ-025 Main draining with skid full: skid moves to main; skid clears.
REQ-026 Order is strictly FIFO; no entry is dropped or duplicated except by flush/reset.
REQ-027 Simultaneous accept and drain with one entry held: occupancy stays 1, main takes new data.
REQ-028 flush_i: next cycle both entries invalid, out_valid_o=0, in_ready_o=1; input presented with flush_i is not accepted and not counted.
REQ-029 flush_i has priority over every accept and drain in that cycle; sel_err_o and err_cnt_o are unaffected by flush_i.
REQ-030 On accepted out-of-range select: sel_err_o sets; err_cnt_o increments, saturating at 255.
REQ-031 out_data_o holds stable while out_valid_o=1 and out_ready_i=0.

Reset
REQ-032 rst takes priority over flush_i and all transfers.
REQ-033 After rst: out_valid_o=0, out_data_o=0, skid entry invalid and zeroed, in_ready_o=1, sel_err_o=0, err_cnt_o=0.
REQ-034 rst asserted mid-operation discards buffered entries with no output transfer in the reset cycle.

Structure
REQ-035 Shared package holds the err_cnt width constant (8), its saturation value (255), and the NSRC legal-range limits.
REQ-036 One sub-module, operand_sel_comb: parametrised combinational NSRC:1 select with zero-on-out-of-range, instantiated once at the input.
REQ-037 Elaboration fails if NSRC is outside 2..16.

Verification
REQ-038 WIDTH=32, NSRC=3, src={0x3,0x2,0x1}, sel=2, out_ready=1 -> out_data=0x3, out_valid=1 one cycle later.
REQ-039 sel=3 with NSRC=3, accepted -> out_data=0x0, sel_err_o=1, err_cnt_o=1; 300 such accepts -> err_cnt_o=255.
REQ-040 out_ready=0, send A then B -> in_ready_o=0 after B; raise out_ready -> outputs A then B, in order, no loss.
REQ-041 Buffer full (A,B), assert flush_i with C valid -> next cycle out_valid=0, in_ready=1; C never appears.
REQ-042 Continuous in_valid and out_ready, 100 entries -> one output per cycle, in order, in_ready never deasserts.
REQ-043 rst asserted with both entries full and sel_err_o=1 -> next cycle all outputs at reset values.
